spi_mem_arbiter: RTL and testbench
==================================

// Module: spi_mem_arbiter
// PURPOSE
//  Shares the SoC's single serial (QSPI flash/PSRAM) memory controller between two
//  requesters: CPU instruction fetch (port I) and CPU data/AMO access (port D).
//  It uses round-robin grant, holds the grant across atomic read-modify-write
//  sequences (lock), and runs a per-transaction watchdog that returns an error
//  instead of hanging the rv32ima core.
// PARAMETERS
//  ADDR_W      24    byte address width presented to memory controller
//  TIMEOUT     1023  max cycles a granted transfer may wait for mem_ready
//  TO_W        10    width of watchdog counter; must hold TIMEOUT
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  i_valid      in   1       fetch request; held until i_ready
//  i_addr       in   ADDR_W  fetch address (read only)
//  i_ready      out  1       one-cycle completion pulse to fetch
//  i_rdata      out  32      fetch data, valid when i_ready
//  i_err        out  1       watchdog error, valid when i_ready
//  d_valid      in   1       data request; held until d_ready
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   32      write data
//  d_wstrb      in   4       byte strobes; 0 = read
//  d_lock       in   1       keep grant on D after this completion (AMO read phase)
//  d_ready      out  1       one-cycle completion pulse to data port
//  d_rdata      out  32      read data, valid when d_ready
//  d_err        out  1       watchdog error, valid when d_ready
//  mem_valid    out  1       request to memory controller
//  mem_addr     out  ADDR_W  muxed address
//  mem_wdata    out  32      muxed write data (0 for fetch)
//  mem_wstrb    out  4       muxed strobes (0 for fetch)
//  mem_ready    in   1       controller completion pulse
//  mem_rdata    in   32      controller read data
//  busy         out  1       a transfer is in flight
// BEHAVIOUR
//  Reset: state IDLE, last_grant=D (so I wins first tie), locked=0, wdog=0; all
//   outputs 0.
//  States: IDLE, GNT_I, GNT_D. Grant is registered: request seen in IDLE -> mem_valid
//   asserted the next cycle; mem_valid/addr/wdata/wstrb stay stable until mem_ready.
//  IDLE: if locked and d_valid -> GNT_D. If locked, I is never granted. Otherwise:
//   only one valid -> grant it; both valid -> grant the port != last_grant.
//  GNT_x on mem_ready: x_ready=1 for exactly one cycle, x_rdata=mem_rdata, x_err=0,
//   last_grant=x, -> IDLE. mem_valid drops in the same cycle as x_ready.
//  The next grant starts no earlier than the cycle after ready (one idle cycle minimum).
//  Lock: locked <= d_lock sampled at D completion; cleared at next D completion with
//   d_lock=0, or by rst. A D error completion also clears locked.
//  Watchdog: wdog counts cycles in GNT_x while mem_ready=0; when wdog==TIMEOUT:
//   x_ready=1, x_err=1, x_rdata=0, mem_valid drops, -> IDLE, wdog cleared. A mem_ready
//   arriving in the same cycle as the timeout wins: normal completion, err=0.
//  Stray mem_ready in IDLE is ignored (no ready to any port).
//  Requester deasserting valid before ready is a protocol violation; the transfer
//   still completes and ready is still pulsed.
//  rst mid-transfer: return to IDLE next edge, outputs 0; in-flight data is dropped.
//  busy = (state != IDLE).
// TESTING
//  1 Fetch alone: i_valid, i_addr=0x000100, mem_ready after 8 cycles, rdata=0x00000013
//    -> mem_valid 1 cycle after request; i_ready pulse with i_rdata=0x00000013.
//  2 Contention: i_valid and d_valid both held for 4 transactions -> grants I,D,I,D
//    after reset; each done after its mem_ready.
//  3 AMO lock: D read with d_lock=1 while i_valid is held -> next grant is D (write,
//    d_lock=0); I is granted only after that D completion.
//  4 Watchdog: grant D, mem_ready never asserted -> d_ready=1, d_err=1 exactly TIMEOUT
//    cycles after mem_valid rises; locked is cleared.
//  5 Timeout race: mem_ready asserted on the timeout cycle -> d_err=0, normal data.
//  6 Reset mid-transfer: rst during GNT_I -> next cycle mem_valid=0, busy=0, no i_ready;
//    a new fetch afterwards completes normally.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
// Shares one serial memory controller between CPU instruction fetch (port I)
// and CPU data/AMO access (port D). Round-robin grant, a lock that keeps the
// grant on D across an atomic read-modify-write, and a per-transaction
// watchdog that completes a stalled transfer with an error.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_valid/i_addr                 fetch request (read only), held until i_ready
//   i_ready/i_rdata/i_err          one-cycle fetch completion, data, timeout flag
//   d_valid/d_addr/d_wdata/d_wstrb data request (wstrb 0 = read), held until d_ready
//   d_lock                         keep grant on D after this completion
//   d_ready/d_rdata/d_err          one-cycle data completion, data, timeout flag
//   mem_valid/mem_addr/mem_wdata/mem_wstrb  request to memory controller
//   mem_ready/mem_rdata            controller completion pulse and read data
//   busy                           a transfer is in flight
module spi_mem_arbiter #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  input  logic              d_lock,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0]      state;
  logic            last_d;   // last completed grant was D
  logic            locked;
  logic [TO_W-1:0] wdog;
  logic            wdog_expired;

  // wdog is 0 in the first granted cycle, so the transfer is abandoned after
  // exactly TIMEOUT cycles of mem_valid without mem_ready.
  assign wdog_expired = (wdog == TO_W'(TIMEOUT - 1));
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      locked    <= 1'b0;
      wdog      <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_ready   <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      i_rdata <= '0;
      i_err   <= 1'b0;
      d_ready <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;

      case (state)
        IDLE: begin
          // The requester still holds valid during its ready cycle; skipping
          // arbitration then avoids re-granting a request already served.
          if (!i_ready && !d_ready) begin
            if (d_valid && (locked || !i_valid || !last_d)) begin
              state     <= GNT_D;
              mem_valid <= 1'b1;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
              wdog      <= '0;
            end else if (i_valid && !locked) begin
              state     <= GNT_I;
              mem_valid <= 1'b1;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              wdog      <= '0;
            end
          end
        end

        GNT_I, GNT_D: begin
          // mem_ready takes priority over a simultaneous watchdog expiry
          if (mem_ready || wdog_expired) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            wdog      <= '0;
            last_d    <= (state == GNT_D);
            if (state == GNT_I) begin
              i_ready <= 1'b1;
              i_err   <= !mem_ready;
              i_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              d_ready <= 1'b1;
              d_err   <= !mem_ready;
              d_rdata <= mem_ready ? mem_rdata : '0;
              locked  <= mem_ready ? d_lock : 1'b0;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
module tb_spi_mem_arbiter;

  localparam int unsigned AW  = 24;
  localparam int unsigned TMO = 12;
  localparam int unsigned TW  = 4;
  localparam int unsigned WAIT_LIMIT = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid, i_ready, i_err;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          d_valid, d_lock, d_ready, d_err;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [3:0]    d_wstrb;
  logic          mem_valid, mem_ready, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TMO), .TO_W(TW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_lock(d_lock),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  // lat: cycles of mem_valid before mem_ready is sampled; 0 = never answer
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          lock;
    int unsigned   lat;
    logic [31:0]   rdata;
  } req_t;

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  req_t iq[$];
  req_t dq[$];
  req_t exp_mem[$];
  rsp_t exp_rsp[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit m_last_d = 1'b1;
  bit m_locked = 1'b0;
  int stray_req = 0;
  int stray_done = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference arbiter: both ports present their lists back to back, so at
  // every decision point a port has a request iff its list is not exhausted.
  function automatic void model_round();
    int   ni, nd;
    bit   hi, hd, pick_d;
    req_t r;
    rsp_t s;
    ni = 0;
    nd = 0;
    while (ni < iq.size() || nd < dq.size()) begin
      hi = (ni < iq.size());
      hd = (nd < dq.size());
      if (m_locked) begin
        if (!hd) break;
        pick_d = 1'b1;
      end else if (hi && hd) begin
        pick_d = !m_last_d;
      end else begin
        pick_d = hd;
      end
      if (pick_d) begin
        r = dq[nd];
        nd++;
      end else begin
        r = iq[ni];
        ni++;
      end
      exp_mem.push_back(r);
      s.port_d = pick_d;
      s.err    = (r.lat == 0);
      s.rdata  = s.err ? 32'h0 : r.rdata;
      exp_rsp.push_back(s);
      m_last_d = pick_d;
      if (pick_d) m_locked = s.err ? 1'b0 : r.lock;
    end
  endfunction

  function automatic req_t mk_req(logic [AW-1:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                                  logic lock, int unsigned lat, logic [31:0] rdata);
    req_t r;
    r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    r.lock = lock; r.lat = lat; r.rdata = rdata;
    return r;
  endfunction

  task automatic drive_i();
    int unsigned cyc;
    for (int k = 0; k < iq.size(); k++) begin
      i_valid = 1'b1;
      i_addr  = iq[k].addr;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!i_ready && cyc < WAIT_LIMIT);
      check("i_ready_wait", {63'd0, i_ready}, 64'd1);
      if (!i_ready) break;
    end
    i_valid = 1'b0;
  endtask

  task automatic drive_d();
    int unsigned cyc;
    for (int k = 0; k < dq.size(); k++) begin
      d_valid = 1'b1;
      d_addr  = dq[k].addr;
      d_wdata = dq[k].wdata;
      d_wstrb = dq[k].wstrb;
      d_lock  = dq[k].lock;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!d_ready && cyc < WAIT_LIMIT);
      check("d_ready_wait", {63'd0, d_ready}, 64'd1);
      if (!d_ready) break;
    end
    d_valid = 1'b0;
    d_lock  = 1'b0;
  endtask

  task automatic run_round();
    model_round();
    fork
      drive_i();
      drive_d();
    join
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_last_d = 1'b1;
    m_locked = 1'b0;
  endtask

  function automatic int unsigned rand_lat();
    int unsigned x;
    x = $urandom_range(0, 15);
    if (x == 0) return 0;
    if (x == 1) return TMO;
    return $urandom_range(1, 6);
  endfunction

  // Memory controller model: checks each request against the expected grant
  // order and answers after the latency chosen for that request.
  initial begin
    int unsigned cnt;
    bit   serving;
    req_t e;
    serving   = 1'b0;
    cnt       = 0;
    e         = mk_req('0, '0, '0, 1'b0, 0, '0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        serving   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        serving   = 1'b0;
        check("mem_valid_drop", {63'd0, mem_valid}, 64'd0);
      end else if (!serving && mem_valid) begin
        if (exp_mem.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_mem_valid: got addr %0h expected no request", mem_addr);
          e = mk_req(mem_addr, mem_wdata, mem_wstrb, 1'b0, 0, '0);
        end else begin
          e = exp_mem.pop_front();
        end
        check("mem_addr", 64'(mem_addr), 64'(e.addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        check("mem_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
        serving = 1'b1;
        cnt = 1;
        if (e.lat == 1) begin
          mem_ready = 1'b1;
          mem_rdata = e.rdata;
        end
      end else if (serving) begin
        if (mem_valid) begin
          cnt++;
          check("mem_addr_stable", 64'(mem_addr), 64'(e.addr));
          if (cnt == e.lat) begin
            mem_ready = 1'b1;
            mem_rdata = e.rdata;
          end
        end else begin
          check("wdog_cycles", 64'(cnt), (e.lat == 0) ? 64'(TMO) : 64'(e.lat));
          serving = 1'b0;
        end
      end else if (stray_done != stray_req) begin
        stray_done++;
        mem_ready = 1'b1;
        mem_rdata = 32'hdead_beef;
      end
    end
  end

  task automatic take_rsp(bit port_d, logic [31:0] rdata, logic err);
    rsp_t s;
    if (exp_rsp.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_ready: got ready on port %s expected none", port_d ? "D" : "I");
    end else begin
      s = exp_rsp.pop_front();
      check("rsp_port", {63'd0, port_d}, {63'd0, s.port_d});
      check("rsp_rdata", 64'(rdata), 64'(s.rdata));
      check("rsp_err", {63'd0, err}, {63'd0, s.err});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (i_ready) take_rsp(1'b0, i_rdata, i_err);
      if (d_ready) take_rsp(1'b1, d_rdata, d_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    int unsigned ni, nd;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0; d_lock = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_readys", {62'd0, i_ready, d_ready}, 64'd0);
    check("rst_errs", {62'd0, i_err, d_err}, 64'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    check("rst_mem_bus", {mem_wdata, mem_wstrb, mem_addr}, 64'd0);
    rst = 1'b0;

    // Fetch alone, mem_valid one cycle after the request is seen
    iq.delete(); dq.delete();
    iq.push_back(mk_req(24'h000100, '0, '0, 1'b0, 8, 32'h0000_0013));
    model_round();
    i_valid = 1'b1;
    i_addr  = 24'h000100;
    @(negedge clk);
    check("fetch_mem_valid_latency", {63'd0, mem_valid}, 64'd1);
    check("fetch_busy", {63'd0, busy}, 64'd1);
    cyc = 0;
    while (!i_ready && cyc < WAIT_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("fetch_ready", {63'd0, i_ready}, 64'd1);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Contention from reset: I,D,I,D
    do_reset();
    iq.delete(); dq.delete();
    iq.push_back(mk_req(24'h000200, '0, '0, 1'b0, 3, 32'h1111_0001));
    iq.push_back(mk_req(24'h000204, '0, '0, 1'b0, 2, 32'h1111_0002));
    dq.push_back(mk_req(24'h800000, 32'hcafe_0001, 4'h0, 1'b0, 4, 32'h2222_0001));
    dq.push_back(mk_req(24'h800004, 32'hcafe_0002, 4'hf, 1'b0, 1, 32'h2222_0002));
    run_round();

    // AMO: locked D write goes ahead of a waiting fetch
    iq.delete(); dq.delete();
    iq.push_back(mk_req(24'h000300, '0, '0, 1'b0, 2, 32'h3333_0001));
    iq.push_back(mk_req(24'h000304, '0, '0, 1'b0, 2, 32'h3333_0002));
    dq.push_back(mk_req(24'h900000, 32'h0, 4'h0, 1'b1, 3, 32'h4444_0001));
    dq.push_back(mk_req(24'h900000, 32'h4444_0002, 4'hf, 1'b0, 2, 32'h0));
    run_round();

    // Watchdog on a locked D read clears the lock, so the fetch wins next
    iq.delete(); dq.delete();
    dq.push_back(mk_req(24'ha00000, 32'h0, 4'h0, 1'b1, 0, 32'h5555_0001));
    dq.push_back(mk_req(24'ha00004, 32'h5555_0002, 4'h3, 1'b0, 3, 32'h0));
    iq.push_back(mk_req(24'h000400, '0, '0, 1'b0, 2, 32'h6666_0001));
    run_round();

    // mem_ready on the timeout cycle completes normally
    iq.delete(); dq.delete();
    dq.push_back(mk_req(24'hb00000, 32'h0, 4'h0, 1'b0, TMO, 32'h7777_0001));
    run_round();

    // Reset in the middle of a fetch
    iq.delete(); dq.delete();
    exp_mem.push_back(mk_req(24'h000500, '0, '0, 1'b0, 0, '0));
    i_valid = 1'b1;
    i_addr  = 24'h000500;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_i_ready", {63'd0, i_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_last_d = 1'b1;
    m_locked = 1'b0;
    iq.push_back(mk_req(24'h000600, '0, '0, 1'b0, 4, 32'h8888_0001));
    run_round();

    // Stray mem_ready while idle must not produce a completion
    stray_req++;
    repeat (4) @(negedge clk);
    check("stray_busy", {63'd0, busy}, 64'd0);

    // Random rounds
    for (int r = 0; r < 40; r++) begin
      iq.delete(); dq.delete();
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 3);
      if (ni == 0 && nd == 0) nd = 1;
      for (int k = 0; k < int'(ni); k++)
        iq.push_back(mk_req(AW'($urandom), '0, '0, 1'b0, rand_lat(), $urandom));
      for (int k = 0; k < int'(nd); k++)
        dq.push_back(mk_req(AW'($urandom), $urandom, 4'($urandom_range(0, 15)),
                            (k < int'(nd) - 1) ? 1'($urandom_range(0, 1)) : 1'b0,
                            rand_lat(), $urandom));
      run_round();
    end

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
    check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
